// File: rtl/conv_serial_sequencer.sv
// Serial-mode convolution sequencer: drives operand reads, MAC strobes and result writes, one tap per cycle.
// Optional macro CONV_SEQ_CORR_MODE_EN adds a corr_mode input selecting unflipped (correlation) B addressing.
module conv_serial_sequencer #(
  parameter int IN_DIM  = 4,
  parameter int K_DIM   = 3,
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 4,
  parameter int RES_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
`ifdef CONV_SEQ_CORR_MODE_EN
  input  logic              corr_mode,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              mac_en,
  output logic              mac_clear,
  output logic              res_wr,
  output logic [RES_W-1:0]  res_addr,
  input  logic              res_ready
);

  localparam int OUT_DIM = IN_DIM - K_DIM + 1;
  localparam int CNT_W   = $clog2(IN_DIM) + 1;
  localparam int DCW     = $clog2(MEM_LAT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   orow_q, ocol_q, kr_q, kc_q;
  logic [CNT_W-1:0]   orow_d, ocol_d, kr_d, kc_d;
  logic               tap_last, out_last;
  logic [DCW-1:0]     drain_q;
  logic               busy_q, done_q, rd_en_q, tap0_q, res_wr_q;
  logic [ADDR_W-1:0]  addr_a_q, addr_b_q;
  logic [RES_W-1:0]   res_addr_q;
  logic [MEM_LAT-1:0] rd_pipe_q, clr_pipe_q;
  logic               corr_sel;

`ifdef CONV_SEQ_CORR_MODE_EN
  logic corr_q;
  // The first tap is addressed in the start cycle, before corr_q has been captured.
  assign corr_sel = (state_q == S_IDLE) ? corr_mode : corr_q;
`else
  assign corr_sel = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] f_addr_a(input logic [CNT_W-1:0] orow, ocol, kr, kc);
    return ADDR_W'((int'(orow) + int'(kr)) * IN_DIM + int'(ocol) + int'(kc));
  endfunction

  function automatic logic [ADDR_W-1:0] f_addr_b(input logic corr, input logic [CNT_W-1:0] kr, kc);
    if (corr) return ADDR_W'(int'(kr) * K_DIM + int'(kc));
    return ADDR_W'((K_DIM - 1 - int'(kr)) * K_DIM + (K_DIM - 1 - int'(kc)));
  endfunction

  function automatic logic [RES_W-1:0] f_res_addr(input logic [CNT_W-1:0] orow, ocol);
    return RES_W'(int'(orow) * OUT_DIM + int'(ocol));
  endfunction

  always_comb begin
    kc_d     = kc_q + 1'b1;
    kr_d     = kr_q;
    ocol_d   = ocol_q + 1'b1;
    orow_d   = orow_q;
    tap_last = (kr_q == CNT_W'(K_DIM - 1)) && (kc_q == CNT_W'(K_DIM - 1));
    out_last = (orow_q == CNT_W'(OUT_DIM - 1)) && (ocol_q == CNT_W'(OUT_DIM - 1));
    if (kc_q == CNT_W'(K_DIM - 1)) begin
      kc_d = '0;
      kr_d = kr_q + 1'b1;
    end
    if (ocol_q == CNT_W'(OUT_DIM - 1)) begin
      ocol_d = '0;
      orow_d = orow_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      orow_q     <= '0;
      ocol_q     <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      tap0_q     <= 1'b0;
      res_wr_q   <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      res_addr_q <= '0;
      rd_pipe_q  <= '0;
      clr_pipe_q <= '0;
`ifdef CONV_SEQ_CORR_MODE_EN
      corr_q     <= 1'b0;
`endif
    end else begin
      // MAC strobes trail the read strobe by the operand memory latency
      rd_pipe_q[0]  <= rd_en_q;
      clr_pipe_q[0] <= tap0_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        rd_pipe_q[i]  <= rd_pipe_q[i-1];
        clr_pipe_q[i] <= clr_pipe_q[i-1];
      end
      done_q <= 1'b0;

      if (abort && state_q != S_IDLE) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        rd_en_q    <= 1'b0;
        tap0_q     <= 1'b0;
        res_wr_q   <= 1'b0;
        rd_pipe_q  <= '0;
        clr_pipe_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q  <= S_ISSUE;
              busy_q   <= 1'b1;
              rd_en_q  <= 1'b1;
              tap0_q   <= 1'b1;
              orow_q   <= '0;
              ocol_q   <= '0;
              kr_q     <= '0;
              kc_q     <= '0;
              addr_a_q <= f_addr_a('0, '0, '0, '0);
              addr_b_q <= f_addr_b(corr_sel, '0, '0);
`ifdef CONV_SEQ_CORR_MODE_EN
              corr_q   <= corr_mode;
`endif
            end
          end
          S_ISSUE: begin
            tap0_q <= 1'b0;
            if (tap_last) begin
              state_q <= S_DRAIN;
              rd_en_q <= 1'b0;
              drain_q <= '0;
            end else begin
              kr_q     <= kr_d;
              kc_q     <= kc_d;
              addr_a_q <= f_addr_a(orow_q, ocol_q, kr_d, kc_d);
              addr_b_q <= f_addr_b(corr_sel, kr_d, kc_d);
            end
          end
          S_DRAIN: begin
            if (drain_q == DCW'(MEM_LAT - 1)) begin
              state_q    <= S_WRITE;
              res_wr_q   <= 1'b1;
              res_addr_q <= f_res_addr(orow_q, ocol_q);
            end else begin
              drain_q <= drain_q + 1'b1;
            end
          end
          S_WRITE: begin
            if (res_ready) begin
              res_wr_q <= 1'b0;
              if (out_last) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q  <= S_ISSUE;
                orow_q   <= orow_d;
                ocol_q   <= ocol_d;
                kr_q     <= '0;
                kc_q     <= '0;
                rd_en_q  <= 1'b1;
                tap0_q   <= 1'b1;
                addr_a_q <= f_addr_a(orow_d, ocol_d, '0, '0);
                addr_b_q <= f_addr_b(corr_sel, '0, '0);
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign mac_en    = rd_pipe_q[MEM_LAT-1];
  assign mac_clear = clr_pipe_q[MEM_LAT-1];
  assign res_wr    = res_wr_q;
  assign res_addr  = res_addr_q;

endmodule

// File: tb/tb_conv_serial_sequencer.sv
// Directed bench for conv_serial_sequencer: default instance plus a MEM_LAT=3 instance.
module tb_conv_serial_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic busy, done, rd_en, mac_en, mac_clear, res_wr;
  logic [3:0] addr_a, addr_b;
  logic [1:0] res_addr;
  logic start3 = 1'b0, abort3 = 1'b0, res_ready3 = 1'b1;
  logic busy3, done3, rd_en3, mac_en3, mac_clear3, res_wr3;
  logic [3:0] addr_a3, addr_b3;
  logic [1:0] res_addr3;
`ifdef CONV_SEQ_CORR_MODE_EN
  logic corr_mode = 1'b0;
  logic corr_mode3 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int atab [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int base [4] = '{0, 1, 4, 5};

  always #5 clk = ~clk;

  conv_serial_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef CONV_SEQ_CORR_MODE_EN
    .corr_mode(corr_mode),
`endif
    .busy(busy), .done(done), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .mac_en(mac_en), .mac_clear(mac_clear), .res_wr(res_wr), .res_addr(res_addr),
    .res_ready(res_ready)
  );

  conv_serial_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
`ifdef CONV_SEQ_CORR_MODE_EN
    .corr_mode(corr_mode3),
`endif
    .busy(busy3), .done(done3), .rd_en(rd_en3), .addr_a(addr_a3), .addr_b(addr_b3),
    .mac_en(mac_en3), .mac_clear(mac_clear3), .res_wr(res_wr3), .res_addr(res_addr3),
    .res_ready(res_ready3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, rd_en, mac_en, mac_clear, res_wr} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=000000", {busy, done, rd_en, mac_en, mac_clear, res_wr});
    end
    checks++;
    if ({addr_a, addr_b, res_addr} !== 10'b0) begin
      failures++;
      $display("FAIL reset_addr got a=%0d b=%0d r=%0d want 0", addr_a, addr_b, res_addr);
    end
    checks++;
    if ({busy3, done3, rd_en3, mac_en3, mac_clear3, res_wr3} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes_lat3 got=%b want=000000", {busy3, done3, rd_en3, mac_en3, mac_clear3, res_wr3});
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Default timing: output o occupies 11 cycles, phase p: 0..8 issue, 9 drain, 10 write.
  task automatic test_full_run;
    logic [5:0] exp_s;
    logic [3:0] ea, eb;
    int o, p;
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 46; n++) begin
      o = (n - 1) / 11;
      p = (n - 1) % 11;
      if (n <= 44)
        exp_s = {1'b1, 1'b0, p < 9, (p >= 1 && p <= 9), p == 1, p == 10};
      else
        exp_s = {n == 45, n == 45, 4'b0};
      checks++;
      if ({busy, done, rd_en, mac_en, mac_clear, res_wr} !== exp_s) begin
        failures++;
        $display("FAIL full_strobes cyc=%0d got=%b want=%b", n, {busy, done, rd_en, mac_en, mac_clear, res_wr}, exp_s);
      end
      if (n <= 44) begin
        ea = 4'(base[o] + atab[(p < 9) ? p : 8]);
        eb = 4'((p < 9) ? 8 - p : 0);
        checks++;
        if (addr_a !== ea || addr_b !== eb) begin
          failures++;
          $display("FAIL full_addr cyc=%0d got a=%0d b=%0d want a=%0d b=%0d", n, addr_a, addr_b, ea, eb);
        end
        if (p == 10) begin
          checks++;
          if (res_addr !== 2'(o)) begin
            failures++;
            $display("FAIL full_res_addr cyc=%0d got=%0d want=%0d", n, res_addr, o);
          end
        end
      end
      start = (n == 20);
      if (n < 46) tick();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back;
    int nwr;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || addr_a !== 4'd0 || addr_b !== 4'd8 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got rd=%b a=%0d b=%0d busy=%b want rd=1 a=0 b=8 busy=1", rd_en, addr_a, addr_b, busy);
    end
    nwr = 0;
    for (int n = 1; n <= 46; n++) begin
      if (res_wr === 1'b1) begin
        checks++;
        if (res_addr !== 2'(nwr)) begin
          failures++;
          $display("FAIL b2b_res_order idx=%0d got=%0d want=%0d", nwr, res_addr, nwr);
        end
        nwr++;
      end
      if (n == 45) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL b2b_done cyc=45 got=%b want=1", done);
        end
      end
      if (n < 46) tick();
    end
    checks++;
    if (nwr != 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_writes got=%0d busy=%b want=4 busy=0", nwr, busy);
    end
  endtask

  task automatic test_stall;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 51; n++) begin
      res_ready = !(n >= 33 && n <= 37);
      if (n >= 33 && n <= 38) begin
        checks++;
        if (res_wr !== 1'b1 || res_addr !== 2'd2 || rd_en !== 1'b0 || mac_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got wr=%b r=%0d rd=%b mac=%b want wr=1 r=2 rd=0 mac=0", n, res_wr, res_addr, rd_en, mac_en);
        end
      end
      if (n == 39) begin
        checks++;
        if (rd_en !== 1'b1 || res_wr !== 1'b0 || addr_a !== 4'd5 || addr_b !== 4'd8) begin
          failures++;
          $display("FAIL stall_resume got rd=%b wr=%b a=%0d b=%0d want rd=1 wr=0 a=5 b=8", rd_en, res_wr, addr_a, addr_b);
        end
      end
      if (n == 49 || n == 50) begin
        checks++;
        if (done !== (n == 50)) begin
          failures++;
          $display("FAIL stall_done cyc=%0d got=%b want=%b", n, done, n == 50);
        end
      end
      if (n == 51) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL stall_idle got busy=%b want=0", busy);
        end
      end
      if (n < 51) tick();
    end
    res_ready = 1'b1;
  endtask

  task automatic test_abort;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 16; n++) tick();
    checks++;
    if (rd_en !== 1'b1 || addr_a !== 4'd6 || addr_b !== 4'd4) begin
      failures++;
      $display("FAIL abort_pre got rd=%b a=%0d b=%0d want rd=1 a=6 b=4", rd_en, addr_a, addr_b);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int n = 0; n < 8; n++) begin
      checks++;
      if ({busy, done, rd_en, mac_en, mac_clear, res_wr} !== 6'b0) begin
        failures++;
        $display("FAIL abort_quiet cyc=%0d got=%b want=000000", n, {busy, done, rd_en, mac_en, mac_clear, res_wr});
      end
      tick();
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_wins got busy=%b rd=%b want 0 0", busy, rd_en);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 11; n++) tick();
    checks++;
    if (res_wr !== 1'b1 || res_addr !== 2'd0) begin
      failures++;
      $display("FAIL abort_restart got wr=%b r=%0d want wr=1 r=0", res_wr, res_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // MEM_LAT=3: 13 cycles per output, phase p: 0..8 issue, 9..11 drain, 12 write.
  task automatic test_memlat3;
    logic [5:0] exp_s;
    logic [3:0] ea;
    int o, p;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int n = 1; n <= 54; n++) begin
      o = (n - 1) / 13;
      p = (n - 1) % 13;
      if (n <= 52)
        exp_s = {1'b1, 1'b0, p < 9, (p >= 3 && p <= 11), p == 3, p == 12};
      else
        exp_s = {n == 53, n == 53, 4'b0};
      checks++;
      if ({busy3, done3, rd_en3, mac_en3, mac_clear3, res_wr3} !== exp_s) begin
        failures++;
        $display("FAIL lat3_strobes cyc=%0d got=%b want=%b", n, {busy3, done3, rd_en3, mac_en3, mac_clear3, res_wr3}, exp_s);
      end
      if (n <= 52 && p < 9) begin
        ea = 4'(base[o] + atab[p]);
        checks++;
        if (addr_a3 !== ea || addr_b3 !== 4'(8 - p)) begin
          failures++;
          $display("FAIL lat3_addr cyc=%0d got a=%0d b=%0d want a=%0d b=%0d", n, addr_a3, addr_b3, ea, 8 - p);
        end
      end
      if (n < 54) tick();
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 6; n++) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, rd_en, mac_en, mac_clear, res_wr} !== 6'b0 || {addr_a, addr_b, res_addr} !== 10'b0) begin
      failures++;
      $display("FAIL reset_mid got s=%b a=%0d b=%0d r=%0d want all 0", {busy, done, rd_en, mac_en, mac_clear, res_wr}, addr_a, addr_b, res_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef CONV_SEQ_CORR_MODE_EN
  task automatic test_corr;
    corr_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    corr_mode = 1'b0;
    for (int p = 0; p < 9; p++) begin
      checks++;
      if (rd_en !== 1'b1 || addr_a !== 4'(atab[p]) || addr_b !== 4'(p)) begin
        failures++;
        $display("FAIL corr_addr tap=%0d got a=%0d b=%0d want a=%0d b=%0d", p, addr_a, addr_b, atab[p], p);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_back_to_back();
    test_stall();
    test_abort();
    test_memlat3();
    test_reset_mid();
`ifdef CONV_SEQ_CORR_MODE_EN
    test_corr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
